// File: rtl/phase_bank.sv
// Phase bank for a transducer array: calibration, shadow and active phase tables.
// Phase writes are calibrated through a two-stage pipeline into the shadow table.
// The shadow table is copied to the active table on a carrier-period tick once a
// commit has been requested.
module phase_bank #(
  parameter int unsigned N_CHANNELS  = 64,
  parameter logic [7:0]  COMMIT_ADDR = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             latest_data,
  input  logic                    phase_parse_en,
  input  logic                    phase_calib_en,
  input  logic                    global_enable,
  input  logic                    period_tick,
  output logic [N_CHANNELS*8-1:0] phases_out,
  output logic [N_CHANNELS-1:0]   channel_en_out,
  output logic                    commit_pending,
  output logic [15:0]             commit_count,
  output logic                    addr_error
);

  logic [7:0] calib_q  [N_CHANNELS];
  logic [7:0] shadow_q [N_CHANNELS];
  logic [7:0] active_q [N_CHANNELS];

  logic       s1_valid_q, s1_commit_q;
  logic [7:0] s1_addr_q, s1_sum_q;

  logic                  pending_q, fresh_q;
  logic [15:0]           count_q;
  logic                  err_q;
  logic [N_CHANNELS-1:0] chen_q;

  logic [7:0] in_addr, in_phase, calib_sel;
  logic       in_commit, is_chan, err_now, commit_now;
  logic       unused_hi;

  assign in_addr   = latest_data[7:0];
  assign in_phase  = latest_data[15:8];
  assign unused_hi = ^latest_data[31:16];

  // Decode the incoming address and read the calibration entry for it.
  // calib_q in the strobe cycle already holds every calib write from earlier cycles
  // but not one strobed in this same cycle, which is exactly the visibility wanted.
  always_comb begin
    in_commit  = (in_addr == COMMIT_ADDR);
    is_chan    = ({24'd0, in_addr} < N_CHANNELS) && !in_commit;
    err_now    = (phase_parse_en && !is_chan && !in_commit) || (phase_calib_en && !is_chan);
    // A request that became pending at the previous edge must wait for a later tick.
    commit_now = period_tick && pending_q && !fresh_q;
    calib_sel  = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      if (in_addr == 8'(i)) calib_sel = calib_q[i];
    end
  end

  // Calibration table and stage-1 pipeline register (address plus calibrated phase).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CHANNELS; i++) calib_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_commit_q <= 1'b0;
      s1_addr_q   <= '0;
      s1_sum_q    <= '0;
    end else begin
      if (phase_calib_en && is_chan) begin
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
          if (in_addr == 8'(i)) calib_q[i] <= in_phase;
        end
      end
      s1_valid_q  <= phase_parse_en && is_chan;
      s1_commit_q <= phase_parse_en && in_commit;
      s1_addr_q   <= in_addr;
      s1_sum_q    <= in_phase + calib_sel;
    end
  end

  // Stage 2: shadow write, and shadow-to-active copy on a qualifying tick.
  // The copy reads shadow_q, so a shadow write landing on the same edge is not included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      if (s1_valid_q) begin
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
          if (s1_addr_q == 8'(i)) shadow_q[i] <= s1_sum_q;
        end
      end
      if (commit_now) begin
        for (int unsigned i = 0; i < N_CHANNELS; i++) active_q[i] <= shadow_q[i];
        count_q <= count_q + 16'd1;
      end
    end
  end

  // Commit request tracking, sticky address error and registered channel enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      fresh_q   <= 1'b0;
      err_q     <= 1'b0;
      chen_q    <= '0;
    end else begin
      // Requests while already pending merge; one arriving on the commit edge re-arms.
      fresh_q <= s1_commit_q && (!pending_q || commit_now);
      if (s1_commit_q) begin
        pending_q <= 1'b1;
      end else if (commit_now) begin
        pending_q <= 1'b0;
      end
      if (err_now) err_q <= 1'b1;
      chen_q <= {N_CHANNELS{global_enable}};
    end
  end

  // Flatten the active table onto the output bus.
  always_comb begin
    phases_out = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) phases_out[8*i +: 8] = active_q[i];
  end

  assign channel_en_out = chen_q;
  assign commit_pending = pending_q;
  assign commit_count   = count_q;
  assign addr_error     = err_q;

endmodule

// File: doc/phase_bank.md
PHASE_BANK -- requirements
Module: phase_bank

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 64, number of transducer channels (legal 1..255).
REQ-002 SHALL have parameter COMMIT_ADDR, default 8'hFF, address that requests a shadow-to-active commit.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port latest_data  input  32  command word from receiver; [7:0]=address, [15:8]=phase, [31:16] ignored.
REQ-006 SHALL have port phase_parse_en  input  1  one-cycle strobe: latest_data holds a phase write.
REQ-007 SHALL have port phase_calib_en  input  1  one-cycle strobe: latest_data holds a calibration write.
REQ-008 SHALL have port global_enable  input  1  level; master output enable.
REQ-009 SHALL have port period_tick  input  1  one-cycle strobe at carrier-period boundary; only legal commit instant.
REQ-010 SHALL have port phases_out  output  N_CHANNELS*8  active phases; channel i at [8i+7:8i].
REQ-011 SHALL have port channel_en_out  output  N_CHANNELS  per-channel drive enable.
REQ-012 SHALL have port commit_pending  output  1  commit requested, not yet applied.
REQ-013 SHALL have port commit_count  output  16  number of commits applied, wraps 16'hFFFF->0.
REQ-014 SHALL have port addr_error  output  1  sticky: out-of-range address seen.

Function
REQ-015 SHALL hold three N_CHANNELS x 8-bit arrays: calib, shadow, active (active drives phases_out directly).
REQ-016 SHALL sample latest_data in the same cycle a strobe is high (cycle T); strobes with latest_data from other cycles are never used.
REQ-017 Calibration write at T SHALL update calib[addr] <= phase at T+1.
REQ-018 Phase write at T SHALL pass a 2-stage pipeline: stage-1 register at T+1, shadow[addr] <= (phase + calib[addr]) mod 256 at T+2.
REQ-019 Phase write SHALL use calib values including every calib write strobed in a strictly earlier cycle (T-1 calib write must be visible; forward if needed).
REQ-020 Both strobes in the same cycle SHALL both be processed; the phase write SHALL use the pre-update calib value.
REQ-021 Back-to-back phase writes every cycle SHALL be accepted with no loss; same-address writes SHALL leave the last one in shadow.
REQ-022 Phase write with addr == COMMIT_ADDR SHALL not touch shadow; it SHALL set commit_pending at T+2.
REQ-023 Address >= N_CHANNELS and != COMMIT_ADDR (either strobe) SHALL be dropped and set addr_error at T+1; calib write to COMMIT_ADDR is likewise an error.
REQ-024 On period_tick with commit_pending=1: active <= shadow (all channels, next edge), commit_pending <= 0, commit_count += 1.
REQ-025 period_tick in the same cycle commit_pending would be set (T+2) SHALL not commit; commit waits for the next tick.
REQ-026 A shadow write completing in the commit cycle SHALL not be included in that commit; it remains in shadow.
REQ-027 Repeated commit requests while pending SHALL merge into one commit.
REQ-028 channel_en_out SHALL equal {N_CHANNELS{global_enable}} registered one cycle; active/shadow contents unaffected by global_enable.
REQ-029 period_tick without commit_pending SHALL have no effect.

Reset
REQ-030 rst=1 SHALL clear calib, shadow, active, phases_out, channel_en_out, commit_pending, commit_count, addr_error, and all pipeline valids on the next edge.
REQ-031 Writes in the pipeline during reset SHALL be discarded; strobes while rst=1 SHALL be ignored.
REQ-032 After reset release, first strobe SHALL be accepted in the cycle rst is sampled low.

Verification
REQ-033 calib[3]=8'h10 at T, phase 8'hF8 to addr 3 at T+1, commit req, tick -> phases_out[31:24]=8'h08, commit_count=1.
REQ-034 Phase writes to addr 0..N_CHANNELS-1 every cycle, commit, tick -> active matches shadow exactly; no tick -> phases_out stays 0, commit_pending=1.
REQ-035 Commit request at T, tick at T+2 -> no commit; tick at T+5 -> commit, commit_pending 0 at T+6.
REQ-036 Phase write to addr N_CHANNELS -> addr_error=1, arrays unchanged; remains 1 until rst.
REQ-037 global_enable 1->0 at T -> channel_en_out all 0 at T+1, phases_out unchanged.
REQ-038 rst asserted while commit pending and a write in stage 1 -> all outputs 0, commit_pending 0, no shadow update after release.
